// File: rtl/dpm_pkg.sv
// Shared types and helpers for the parametrised simple dual-port memory.
//   collision_e : same-address read/write policy selector
//   count_w     : width of the occupancy counter for a given address width
package dpm_pkg;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } collision_e;

  // One extra bit so the counter can hold DEPTH itself.
  function automatic int unsigned count_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Bare storage array with registered read and no reset, shaped for block RAM inference.
// Ports:
//   clk           clock
//   we/waddr/wdata write port
//   re/raddr      read port; rdata updates only on re and holds otherwise
//   rdata         registered read data (pre-write content on same-address access)
module sdp_ram_core #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read; callers keep both addresses in range.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdp_mem_param.sv
// Parametrised simple dual-port memory with per-entry valid tracking,
// single-cycle clear, selectable collision policy, optional output register
// and occupancy count.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous clear of all valid bits (drops a same-cycle write)
//   we, waddr, wdata    write port
//   re, raddr           read port
//   rdata, rvalid, rhit read result, one-cycle valid pulse, entry-was-valid flag
//   count               number of valid entries
module sdp_mem_param
  import dpm_pkg::*;
#(
  parameter int unsigned DATA_W    = 13,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned OUT_REG   = 0,
  parameter collision_e  COLLISION = WRITE_FIRST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rhit,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned      CNT_W   = count_w(ADDR_W);
  localparam int unsigned      AW1     = ADDR_W + 1;
  localparam logic [AW1-1:0]   DEPTH_A = AW1'(DEPTH);

  logic [DEPTH-1:0]  valid;
  logic              w_in;
  logic              r_in;
  logic              w_ok;
  logic              fwd;
  logic              hit_now;
  logic [DATA_W-1:0] core_q;

  // Stage-1 read pipeline: qualifiers captured at the read edge.
  logic              s1_valid;
  logic              s1_hit;
  logic              s1_fwd;
  logic [DATA_W-1:0] s1_fdata;
  logic [DATA_W-1:0] s1_data;

  assign w_in    = {1'b0, waddr} < DEPTH_A;
  assign r_in    = {1'b0, raddr} < DEPTH_A;
  assign w_ok    = we & ~clr & w_in;
  assign hit_now = r_in & valid[raddr];
  // Bypass only exists for write-first and only when the write really lands.
  assign fwd     = (COLLISION == WRITE_FIRST) & w_ok & re & (waddr == raddr);

  sdp_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (w_ok),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re & r_in),
    .raddr (raddr),
    .rdata (core_q)
  );

  // Valid vector and occupancy count; clear wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      count <= '0;
    end else if (clr) begin
      valid <= '0;
      count <= '0;
    end else if (w_ok) begin
      valid[waddr] <= 1'b1;
      if (!valid[waddr]) count <= count + CNT_W'(1);
    end
  end

  // Read qualifiers; held between reads so the result holds too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_fwd   <= 1'b0;
      s1_fdata <= '0;
    end else begin
      s1_valid <= re;
      if (re) begin
        s1_hit   <= hit_now | fwd;
        s1_fwd   <= fwd;
        s1_fdata <= wdata;
      end
    end
  end

  // Invalid or out-of-range entries read as zero; core_q is don't-care then.
  assign s1_data = s1_fwd ? s1_fdata : (s1_hit ? core_q : '0);

  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid <= 1'b0;
        rhit   <= 1'b0;
        rdata  <= '0;
      end else begin
        rvalid <= s1_valid;
        if (s1_valid) begin
          rhit  <= s1_hit;
          rdata <= s1_data;
        end
      end
    end
  end else begin : g_noreg
    assign rvalid = s1_valid;
    assign rhit   = s1_hit;
    assign rdata  = s1_data;
  end

endmodule

// File: tb/tb_sdp_mem_param.sv
// Bench for sdp_mem_param: three configurations share one stimulus stream
//   0: DEPTH=16, WRITE_FIRST, OUT_REG=0
//   1: DEPTH=16, READ_FIRST,  OUT_REG=1
//   2: DEPTH=12, WRITE_FIRST, OUT_REG=0
// and are compared each cycle against an array/queue model of the memory.
module tb_sdp_mem_param;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        we;
  logic [3:0]  waddr;
  logic [12:0] wdata;
  logic        re;
  logic [3:0]  raddr;

  logic [12:0] rd  [3];
  logic        rv  [3];
  logic        rh  [3];
  logic [4:0]  cnt [3];

  int errors = 0;
  int checks = 0;

  // Model state
  logic [12:0] mm [3][16];
  bit          vv [3][16];
  bit          pv [3];
  bit          ph [3];
  logic [12:0] pd [3];
  bit          ev [3];
  bit          eh [3];
  logic [12:0] ed [3];
  int          dep [3] = '{16, 16, 12};
  bit          wf  [3] = '{1'b1, 1'b0, 1'b1};
  int          lat [3] = '{1, 2, 1};

  sdp_mem_param #(.DATA_W(13), .DEPTH(16), .OUT_REG(0), .COLLISION(dpm_pkg::WRITE_FIRST)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rd[0]), .rvalid(rv[0]), .rhit(rh[0]), .count(cnt[0]));

  sdp_mem_param #(.DATA_W(13), .DEPTH(16), .OUT_REG(1), .COLLISION(dpm_pkg::READ_FIRST)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rd[1]), .rvalid(rv[1]), .rhit(rh[1]), .count(cnt[1]));

  sdp_mem_param #(.DATA_W(13), .DEPTH(12), .OUT_REG(0), .COLLISION(dpm_pkg::WRITE_FIRST)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rd[2]), .rvalid(rv[2]), .rhit(rh[2]), .count(cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int occupancy(input int i);
    int n = 0;
    for (int k = 0; k < 16; k++) n += int'(vv[i][k]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 16; k++) vv[i][k] = 1'b0;
      pv[i] = 1'b0; ph[i] = 1'b0; pd[i] = '0;
      ev[i] = 1'b0; eh[i] = 1'b0; ed[i] = '0;
    end
  endtask

  // Effect of the coming clock edge given the currently driven inputs.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit          h;
      logic [12:0] d;
      h = (int'(raddr) < dep[i]) && vv[i][raddr];
      d = h ? mm[i][raddr] : 13'h0;
      if (wf[i] && we && !clr && int'(waddr) < dep[i] && waddr == raddr) begin
        h = 1'b1;
        d = wdata;
      end
      if (clr) begin
        for (int k = 0; k < 16; k++) vv[i][k] = 1'b0;
      end else if (we && int'(waddr) < dep[i]) begin
        mm[i][waddr] = wdata;
        vv[i][waddr] = 1'b1;
      end
      if (lat[i] == 1) begin
        ev[i] = re;
        if (re) begin eh[i] = h; ed[i] = d; end
      end else begin
        ev[i] = pv[i];
        if (pv[i]) begin eh[i] = ph[i]; ed[i] = pd[i]; end
        pv[i] = re;
        if (re) begin ph[i] = h; pd[i] = d; end
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rvalid[%0d]", i), 32'(rv[i]),  32'(ev[i]));
      chk($sformatf("rhit[%0d]", i),   32'(rh[i]),  32'(eh[i]));
      chk($sformatf("rdata[%0d]", i),  32'(rd[i]),  32'(ed[i]));
      chk($sformatf("count[%0d]", i),  32'(cnt[i]), 32'(occupancy(i)));
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input bit w, input int wa, input int wd, input bit r, input int ra, input bit c);
    we    = w;
    waddr = 4'(wa);
    wdata = 13'(wd);
    re    = r;
    raddr = 4'(ra);
    clr   = c;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    chk("reset_rvalid", 32'(rv[0]), 32'd0);
    chk("reset_count",  32'(cnt[0]), 32'd0);
    rst_n = 1'b1;

    // Read of an unwritten entry
    cyc(1'b0, 0, 0, 1'b1, 5, 1'b0);
    chk("empty_rvalid", 32'(rv[0]), 32'd1);
    chk("empty_rdata",  32'(rd[0]), 32'd0);
    chk("empty_rhit",   32'(rh[0]), 32'd0);
    chk("empty_count",  32'(cnt[0]), 32'd0);

    // Write, read back, overwrite
    cyc(1'b1, 3, 'h1ABC, 1'b0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 3, 1'b0);
    chk("wr_rdata", 32'(rd[0]), 32'h1ABC);
    chk("wr_rhit",  32'(rh[0]), 32'd1);
    chk("wr_count", 32'(cnt[0]), 32'd1);
    cyc(1'b1, 3, 'h0001, 1'b0, 0, 1'b0);
    chk("ovw_count", 32'(cnt[0]), 32'd1);

    // Same-address collisions
    cyc(1'b1, 7, 'h0123, 1'b0, 0, 1'b0);
    cyc(1'b1, 7, 'h0F0F, 1'b1, 7, 1'b0);
    chk("wf_rdata", 32'(rd[0]), 32'h0F0F);
    idle();
    chk("rf_rdata", 32'(rd[1]), 32'h0123);
    chk("rf_rhit",  32'(rh[1]), 32'd1);
    cyc(1'b1, 8, 'h0F0F, 1'b1, 8, 1'b0);
    idle();
    chk("rf_new_rdata", 32'(rd[1]), 32'd0);
    chk("rf_new_rhit",  32'(rh[1]), 32'd0);

    // Fill, then clear with a dropped simultaneous write
    for (int a = 0; a < 16; a++) cyc(1'b1, a, a * 3 + 1, 1'b0, 0, 1'b0);
    chk("full_count16", 32'(cnt[0]), 32'd16);
    chk("full_count12", 32'(cnt[2]), 32'd12);
    cyc(1'b1, 0, 'h1555, 1'b1, 4, 1'b1);
    chk("clr_count", 32'(cnt[0]), 32'd0);
    chk("clr_preread", 32'(rd[0]), 32'd13);
    cyc(1'b0, 0, 0, 1'b1, 0, 1'b0);
    chk("clr_rdata", 32'(rd[0]), 32'd0);
    chk("clr_rhit",  32'(rh[0]), 32'd0);

    // Back-to-back reads through the output register
    cyc(1'b1, 1, 'h111, 1'b0, 0, 1'b0);
    cyc(1'b1, 2, 'h222, 1'b0, 0, 1'b0);
    cyc(1'b1, 3, 'h333, 1'b0, 0, 1'b0);
    idle();
    cyc(1'b0, 0, 0, 1'b1, 1, 1'b0);
    chk("or_lat_rvalid", 32'(rv[1]), 32'd0);
    cyc(1'b0, 0, 0, 1'b1, 2, 1'b0);
    chk("or_first", 32'(rd[1]), 32'h111);
    cyc(1'b0, 0, 0, 1'b1, 3, 1'b0);
    chk("or_second", 32'(rd[1]), 32'h222);
    idle();
    chk("or_third", 32'(rd[1]), 32'h333);
    chk("or_third_rvalid", 32'(rv[1]), 32'd1);
    idle();
    chk("or_done_rvalid", 32'(rv[1]), 32'd0);

    // Asynchronous reset with reads in flight
    we = 1'b0; clr = 1'b0; re = 1'b1; raddr = 4'd1;
    model_step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    chk("arst_rvalid0", 32'(rv[0]), 32'd0);
    chk("arst_rdata0",  32'(rd[0]), 32'd0);
    chk("arst_count0",  32'(cnt[0]), 32'd0);
    re = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("arst_stale1", 32'(rv[1]), 32'd0);
    idle();

    // Out-of-range access on the 12-entry instance
    cyc(1'b1, 2, 'h0AAA, 1'b0, 0, 1'b0);
    cyc(1'b1, 13, 'h1FFF, 1'b0, 0, 1'b0);
    chk("oor_count", 32'(cnt[2]), 32'd1);
    cyc(1'b0, 0, 0, 1'b1, 13, 1'b0);
    chk("oor_rvalid", 32'(rv[2]), 32'd1);
    chk("oor_rdata",  32'(rd[2]), 32'd0);
    chk("oor_rhit",   32'(rh[2]), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 8191)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdp_mem_param.md
Name: sdp_mem_param

Overview:
- Parametrised simple dual-port memory: one write port, one read port, one clock.
- Successor to the fixed 13-bit game-state store. Adds configurable width and depth, per-entry valid tracking, a single-cycle clear, a selectable read-during-write policy, an optional output register and an occupancy count.
- Used by the deck and hand bookkeeping logic. Reads of never-written entries return a defined zero.

Parameters:
- DATA_W, 13, data width in bits.
- DEPTH, 16, number of entries (any value ≥ 2, power of two not required).
- ADDR_W, $clog2(DEPTH), address width. Derived; do not override.
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- COLLISION, WRITE_FIRST, read/write same-address policy: WRITE_FIRST or READ_FIRST (dpm_pkg enum).

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of all valid bits.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  1  read enable.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  read data, qualified by rvalid.
- rvalid  out  1  one-cycle pulse, read result present.
- rhit  out  1  addressed entry was valid, qualified by rvalid.
- count  out  ADDR_W+1  number of valid entries.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - valid[] all 0; rdata=0, rvalid=0, rhit=0, count=0.
  - Pipeline registers cleared; in-flight reads are dropped and produce no rvalid after reset releases.
  - Storage array is not reset. Contents are undefined but masked by valid.
- Write: at posedge with we=1, clr=0 and waddr<DEPTH:
  - mem[waddr]←wdata, valid[waddr]←1.
  - count increments only if valid[waddr] was 0. An overwrite leaves count unchanged.
- Read: at posedge with re=1, a result is produced.
  - OUT_REG=0: result visible the cycle after the edge (latency 1).
  - OUT_REG=1: latency 2.
  - rvalid is high exactly one cycle per accepted read. Back-to-back reads sustain 1 result/cycle.
  - rdata = valid ? mem : 0; rhit = valid.
  - When rvalid=0, rdata and rhit hold their previous values.
- Collision (re & we, raddr==waddr, clr=0):
  - WRITE_FIRST: rdata=wdata, rhit=1.
  - READ_FIRST: pre-write content and valid bit (0/0 if the entry was previously invalid).
- Clear (clr=1 at posedge):
  - All valid←0, count←0.
  - A simultaneous write is dropped: no data write, no valid set, no forwarding.
  - A simultaneous read returns pre-clear state.
  - Storage contents are untouched.
- Out-of-range addresses (≥DEPTH, only possible when DEPTH is not a power of two):
  - Write ignored.
  - Read still produces rvalid, with rdata=0 and rhit=0.
- count never exceeds DEPTH. It reaches DEPTH when every entry is valid and stays there on overwrites.
- No backpressure: rvalid must be consumed in the cycle it is high.

Decomposition:
- Package dpm_pkg:
  - collision_e enum {WRITE_FIRST, READ_FIRST}.
  - Helper function for the count width (ADDR_W+1).
- Sub-module sdp_ram_core: the bare storage array, with registered read and no reset, so tools infer block RAM.
- The top level holds the valid vector, collision bypass, clear logic, count and output pipeline.

Test Plan:
- Reset then read addr 5 (no writes) → one cycle later rvalid=1, rdata=0, rhit=0, count=0.
- Write 0x1ABC to addr 3, next cycle read addr 3 → rdata=0x1ABC, rhit=1, count=1. Rewrite addr 3 with 0x0001 → count stays 1.
- Same-cycle write 0x0F0F and read, both at addr 7, with addr 7 previously holding 0x0123:
  - WRITE_FIRST → 0x0F0F.
  - READ_FIRST → 0x0123.
  - Repeat on never-written addr 8 under READ_FIRST → rdata=0, rhit=0.
- Fill all 16 entries → count=16. Assert clr together with a write to addr 0 → count=0, later read of addr 0 → rdata=0, rhit=0.
- OUT_REG=1: reads at addrs 1, 2, 3 on consecutive cycles → rvalid high for 3 consecutive cycles starting 2 cycles after the first read, data in order.
- Read issued, rst_n pulled low mid-flight asynchronously → rvalid, rdata and count go 0 immediately, with no stale rvalid after release. DEPTH=12 run: write to addr 13 ignored (count unchanged), read of addr 13 → rvalid=1, rdata=0.
